// File: rtl/isp_stream_pkg.sv
// ============================================================================
// isp_stream_pkg : shared types and default geometry for the Bayer source
// Revision 1.0
// ============================================================================
`default_nettype none

package isp_stream_pkg;

  localparam int C_DEFAULT_WIDTH       = 320;
  localparam int C_DEFAULT_HEIGHT      = 240;
  localparam int C_DEFAULT_HBLANK      = 16;
  localparam int C_DEFAULT_LEAD_CYCLES = 31;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOF    = 3'd1,
    ST_LEAD   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_FLUSH  = 3'd5,
    ST_FBLANK = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  // Named as even-row pair followed by odd-row pair, even column first.
  typedef enum logic [1:0] {
    PAT_GBRG = 2'd0,
    PAT_BGGR = 2'd1,
    PAT_RGGB = 2'd2,
    PAT_GRBG = 2'd3
  } bayer_pat_t;

endpackage

`default_nettype wire

// File: rtl/bayer_sample_sel.sv
// ============================================================================
// bayer_sample_sel : picks the R/G/B channel for one Bayer mosaic position
// Revision 1.0
// ============================================================================
`default_nettype none

module bayer_sample_sel
  import isp_stream_pkg::*;
(
  input  bayer_pat_t  pattern,
  input  logic        row_odd,
  input  logic        col_odd,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic [7:0]  sample
);

  logic [1:0] w_pos;
  assign w_pos = {row_odd, col_odd};

  // Green sits on the diagonal or anti-diagonal; only the R/B corners differ.
  always_comb begin
    sample = g;
    case (pattern)
      PAT_GBRG: begin
        if (w_pos == 2'b01) sample = b;
        if (w_pos == 2'b10) sample = r;
      end
      PAT_BGGR: begin
        if (w_pos == 2'b00) sample = b;
        if (w_pos == 2'b11) sample = r;
      end
      PAT_RGGB: begin
        if (w_pos == 2'b00) sample = r;
        if (w_pos == 2'b11) sample = b;
      end
      PAT_GRBG: begin
        if (w_pos == 2'b01) sample = r;
        if (w_pos == 2'b10) sample = b;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bayer_stream_tx.sv
// ============================================================================
// bayer_stream_tx : RGB raster in, Bayer raw stream out with frame framing,
//                   trailing flush rows until the downstream ISP drains.
// Revision 1.0
// ============================================================================
`default_nettype none

module bayer_stream_tx
  import isp_stream_pkg::*;
#(
  parameter int width      = C_DEFAULT_WIDTH,
  parameter int height     = C_DEFAULT_HEIGHT,
  parameter int hBlank     = C_DEFAULT_HBLANK,
  parameter int leadCycles = C_DEFAULT_LEAD_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iStart,
  input  logic [1:0] iPattern,
  input  logic       iValid,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  output logic       oReady,
  input  logic       iDrainDone,
  output logic       newFrame,
  output logic       oValid,
  output logic [7:0] oData,
  output logic       oDone
);

  localparam int CW = (width      > 1) ? $clog2(width)      : 1;
  localparam int RW = (height     > 1) ? $clog2(height)     : 1;
  localparam int BW = (hBlank     > 1) ? $clog2(hBlank)     : 1;
  localparam int LW = (leadCycles > 1) ? $clog2(leadCycles) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(width - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(height - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(hBlank - 1);
  localparam logic [LW-1:0] LEAD_LAST  = LW'(leadCycles - 1);

  state_t        r_state;
  bayer_pat_t    r_pattern;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [BW-1:0] r_blank;
  logic [LW-1:0] r_lead;
  logic          r_drain;
  logic [7:0]    w_sample;

  bayer_sample_sel u_sel (
    .pattern (r_pattern),
    .row_odd (r_row[0]),
    .col_odd (r_col[0]),
    .r       (iR),
    .g       (iG),
    .b       (iB),
    .sample  (w_sample)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pattern <= PAT_GBRG;
      r_col     <= '0;
      r_row     <= '0;
      r_blank   <= '0;
      r_lead    <= '0;
      r_drain   <= 1'b0;
      oReady    <= 1'b0;
      newFrame  <= 1'b0;
      oValid    <= 1'b0;
      oData     <= '0;
      oDone     <= 1'b0;
    end else begin
      newFrame <= 1'b0;
      oValid   <= 1'b0;
      oData    <= '0;
      oDone    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            r_pattern <= bayer_pat_t'(iPattern);
            newFrame  <= 1'b1;
            r_state   <= ST_SOF;
          end
        end
        ST_SOF: r_state <= ST_LEAD;
        ST_LEAD: begin
          if (r_lead == LEAD_LAST) begin
            r_lead  <= '0;
            oReady  <= 1'b1;
            r_state <= ST_ACTIVE;
          end else begin
            r_lead <= r_lead + LW'(1);
          end
        end
        ST_ACTIVE: begin
          if (iValid) begin
            oValid <= 1'b1;
            oData  <= w_sample;
            if (r_col == COL_LAST) begin
              r_col   <= '0;
              oReady  <= 1'b0;
              r_state <= ST_HBLANK;
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        ST_HBLANK: begin
          if (r_blank == BLANK_LAST) begin
            r_blank <= '0;
            if (r_row == ROW_LAST) begin
              r_row   <= '0;
              r_state <= ST_FLUSH;
            end else begin
              r_row   <= r_row + RW'(1);
              oReady  <= 1'b1;
              r_state <= ST_ACTIVE;
            end
          end else begin
            r_blank <= r_blank + BW'(1);
          end
        end
        ST_FLUSH: begin
          // Zero-valued rows keep the ISP pipeline moving until it drains.
          oValid  <= 1'b1;
          r_drain <= r_drain | iDrainDone;
          if (r_col == COL_LAST) begin
            r_col   <= '0;
            r_state <= ST_FBLANK;
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        ST_FBLANK: begin
          r_drain <= r_drain | iDrainDone;
          if (r_blank == BLANK_LAST) begin
            r_blank <= '0;
            if (r_drain || iDrainDone) begin
              oDone   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_FLUSH;
            end
          end else begin
            r_blank <= r_blank + BW'(1);
          end
        end
        ST_DONE: begin
          r_col   <= '0;
          r_row   <= '0;
          r_blank <= '0;
          r_lead  <= '0;
          r_drain <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bayer_stream_tx.sv
// ============================================================================
// tb_bayer_stream_tx : directed scenarios on a 4x2 frame, hBlank 16, lead 31
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_bayer_stream_tx;

  logic       clk;
  logic       reset;
  logic       iStart;
  logic [1:0] iPattern;
  logic       iValid;
  logic [7:0] iR;
  logic [7:0] iG;
  logic [7:0] iB;
  logic       oReady;
  logic       iDrainDone;
  logic       newFrame;
  logic       oValid;
  logic [7:0] oData;
  logic       oDone;

  int checks;
  int errors;

  logic       cap_nf  [128];
  logic       cap_ov  [128];
  logic       cap_rdy [128];
  logic       cap_dn  [128];
  logic [7:0] cap_od  [128];
  logic [11:0] snap;

  bayer_stream_tx #(
    .width      (4),
    .height     (2),
    .hBlank     (16),
    .leadCycles (31)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iStart     (iStart),
    .iPattern   (iPattern),
    .iValid     (iValid),
    .iR         (iR),
    .iG         (iG),
    .iB         (iB),
    .oReady     (oReady),
    .iDrainDone (iDrainDone),
    .newFrame   (newFrame),
    .oValid     (oValid),
    .oData      (oData),
    .oDone      (oDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle n is sampled at the negedge after the edge that entered SOF.
  // Source ramp: pixel k carries R=k, G=k+64, B=k+128.
  task automatic capture(input logic [1:0] pat, input int ncyc, input bit toggle,
                         input int drain_a, input int drain_b, input int start_at,
                         input int reset_at);
    int idx;
    bit acc;
    idx = 0;
    acc = 1'b0;
    @(negedge clk);
    iPattern = pat;
    iStart   = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (acc) idx++;
      cap_nf[n]  = newFrame;
      cap_ov[n]  = oValid;
      cap_od[n]  = oData;
      cap_rdy[n] = oReady;
      cap_dn[n]  = oDone;
      iPattern   = ~pat;
      iStart     = (n == start_at);
      iDrainDone = (n == drain_a) || (n == drain_b);
      if (n == reset_at) begin
        reset = 1'b1;
        #1;
        snap = {newFrame, oValid, oReady, oDone, oData};
      end
      if (n == reset_at + 2) reset = 1'b0;
      iValid = toggle ? (n % 2 == 0) : 1'b1;
      iR = 8'(idx);
      iG = 8'(idx + 64);
      iB = 8'(idx + 128);
      acc = oReady && iValid && !reset;
    end
    iStart     = 1'b0;
    iDrainDone = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (newFrame !== 1'b0) begin errors++; $display("FAIL reset_newFrame: got %b want 0", newFrame); end
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_oValid: got %b want 0", oValid); end
    checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL reset_oReady: got %b want 0", oReady); end
    checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL reset_oDone: got %b want 0", oDone); end
    checks++; if (oData !== 8'd0) begin errors++; $display("FAIL reset_oData: got %0d want 0", oData); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ({newFrame, oReady, oValid} !== 3'b000) begin errors++; $display("FAIL idle_quiet: got %b want 000", {newFrame, oReady, oValid}); end
  endtask

  task automatic test_pattern0();
    logic [7:0] exp0 [4] = '{8'd64, 8'd129, 8'd66, 8'd131};
    logic [7:0] exp1 [4] = '{8'd4, 8'd69, 8'd6, 8'd71};
    int cnt;
    int first;
    capture(2'd0, 100, 1'b0, 74, -1, -1, -1);
    cnt = 0; first = -1;
    for (int n = 0; n < 100; n++) begin
      if (cap_nf[n]) cnt++;
      if (cap_ov[n] && first < 0) first = n;
    end
    checks++; if (cap_nf[0] !== 1'b1 || cnt != 1) begin errors++; $display("FAIL p0_newFrame: first %b count %0d want 1 1", cap_nf[0], cnt); end
    checks++; if ({cap_rdy[31], cap_rdy[32]} !== 2'b01) begin errors++; $display("FAIL p0_lead_ready: got %b want 01", {cap_rdy[31], cap_rdy[32]}); end
    checks++; if (first != 33) begin errors++; $display("FAIL p0_first_valid: got %0d want 33", first); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_ov[33+k] !== 1'b1 || cap_od[33+k] !== exp0[k]) begin errors++; $display("FAIL p0_row0_px%0d: got %b/%0d want 1/%0d", k, cap_ov[33+k], cap_od[33+k], exp0[k]); end
      checks++; if (cap_ov[53+k] !== 1'b1 || cap_od[53+k] !== exp1[k]) begin errors++; $display("FAIL p0_row1_px%0d: got %b/%0d want 1/%0d", k, cap_ov[53+k], cap_od[53+k], exp1[k]); end
      checks++; if (cap_ov[73+k] !== 1'b1 || cap_od[73+k] !== 8'd0) begin errors++; $display("FAIL p0_flush_px%0d: got %b/%0d want 1/0", k, cap_ov[73+k], cap_od[73+k]); end
    end
    cnt = 0;
    for (int n = 37; n <= 52; n++) if (cap_ov[n]) cnt++;
    for (int n = 57; n <= 72; n++) if (cap_ov[n]) cnt++;
    checks++; if (cnt != 0) begin errors++; $display("FAIL p0_hblank_idle: got %0d valid cycles want 0", cnt); end
    cnt = 0;
    for (int n = 0; n < 100; n++) if (cap_dn[n]) cnt++;
    checks++; if (cap_dn[92] !== 1'b1 || cnt != 1) begin errors++; $display("FAIL p0_done: at92 %b count %0d want 1 1", cap_dn[92], cnt); end
    checks++; if ({cap_rdy[93], cap_ov[93], cap_ov[77]} !== 3'b000) begin errors++; $display("FAIL p0_after_done: got %b want 000", {cap_rdy[93], cap_ov[93], cap_ov[77]}); end
  endtask

  task automatic test_pattern2();
    logic [7:0] exp0 [4] = '{8'd0, 8'd65, 8'd2, 8'd67};
    logic [7:0] exp1 [4] = '{8'd68, 8'd133, 8'd70, 8'd135};
    capture(2'd2, 100, 1'b0, 74, -1, -1, -1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_ov[33+k] !== 1'b1 || cap_od[33+k] !== exp0[k]) begin errors++; $display("FAIL p2_row0_px%0d: got %b/%0d want 1/%0d", k, cap_ov[33+k], cap_od[33+k], exp0[k]); end
      checks++; if (cap_ov[53+k] !== 1'b1 || cap_od[53+k] !== exp1[k]) begin errors++; $display("FAIL p2_row1_px%0d: got %b/%0d want 1/%0d", k, cap_ov[53+k], cap_od[53+k], exp1[k]); end
    end
    checks++; if (cap_dn[92] !== 1'b1) begin errors++; $display("FAIL p2_done: got %b want 1", cap_dn[92]); end
  endtask

  task automatic test_stall();
    logic       ev0 [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ed0 [7] = '{8'd128, 8'd0, 8'd65, 8'd0, 8'd130, 8'd0, 8'd67};
    logic       ev1 [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ed1 [9] = '{8'd0, 8'd0, 8'd68, 8'd0, 8'd5, 8'd0, 8'd70, 8'd0, 8'd7};
    int cnt;
    capture(2'd1, 110, 1'b1, 81, -1, -1, -1);
    for (int k = 0; k < 7; k++) begin
      checks++; if (cap_ov[33+k] !== ev0[k] || cap_od[33+k] !== ed0[k]) begin errors++; $display("FAIL stall_row0_c%0d: got %b/%0d want %b/%0d", 33+k, cap_ov[33+k], cap_od[33+k], ev0[k], ed0[k]); end
    end
    for (int k = 0; k < 9; k++) begin
      checks++; if (cap_ov[55+k] !== ev1[k] || cap_od[55+k] !== ed1[k]) begin errors++; $display("FAIL stall_row1_c%0d: got %b/%0d want %b/%0d", 55+k, cap_ov[55+k], cap_od[55+k], ev1[k], ed1[k]); end
    end
    cnt = 0;
    for (int n = 33; n <= 79; n++) if (cap_ov[n]) cnt++;
    checks++; if (cnt != 8) begin errors++; $display("FAIL stall_sample_count: got %0d want 8", cnt); end
    checks++; if ({cap_ov[80], cap_ov[83], cap_ov[84], cap_dn[99]} !== 4'b1101) begin errors++; $display("FAIL stall_flush_done: got %b want 1101", {cap_ov[80], cap_ov[83], cap_ov[84], cap_dn[99]}); end
  endtask

  task automatic test_drain_late();
    int cnt;
    int nf;
    capture(2'd0, 120, 1'b0, 40, 94, 74, -1);
    cnt = 0; nf = 0;
    for (int n = 0; n < 120; n++) begin
      if (cap_dn[n]) cnt++;
      if (cap_nf[n]) nf++;
    end
    checks++; if (cap_dn[112] !== 1'b1 || cnt != 1) begin errors++; $display("FAIL drain_done: at112 %b count %0d want 1 1", cap_dn[112], cnt); end
    checks++; if (nf != 1) begin errors++; $display("FAIL drain_start_ignored: newFrame count %0d want 1", nf); end
    cnt = 0;
    for (int n = 93; n <= 96; n++) if (cap_ov[n] && cap_od[n] == 8'd0) cnt++;
    checks++; if (cnt != 4) begin errors++; $display("FAIL drain_flush2: got %0d samples want 4", cnt); end
    cnt = 0;
    for (int n = 97; n < 120; n++) if (cap_ov[n] || cap_rdy[n]) cnt++;
    checks++; if (cnt != 0) begin errors++; $display("FAIL drain_idle_after: got %0d busy cycles want 0", cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp0 [4] = '{8'd64, 8'd1, 8'd66, 8'd3};
    logic [7:0] exp1 [4] = '{8'd132, 8'd69, 8'd134, 8'd71};
    int cnt;
    capture(2'd0, 70, 1'b0, -1, -1, -1, 54);
    checks++; if (cap_ov[54] !== 1'b1 || cap_od[54] !== 8'd69) begin errors++; $display("FAIL rst_before: got %b/%0d want 1/69", cap_ov[54], cap_od[54]); end
    checks++; if (snap !== 12'd0) begin errors++; $display("FAIL rst_immediate: got %h want 000", snap); end
    cnt = 0;
    for (int n = 55; n < 70; n++) if (cap_ov[n] || cap_rdy[n] || cap_dn[n] || cap_nf[n]) cnt++;
    checks++; if (cnt != 0) begin errors++; $display("FAIL rst_quiet: got %0d active cycles want 0", cnt); end
    capture(2'd3, 100, 1'b0, 74, -1, -1, -1);
    checks++; if (cap_nf[0] !== 1'b1) begin errors++; $display("FAIL rst_restart_sof: got %b want 1", cap_nf[0]); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_ov[33+k] !== 1'b1 || cap_od[33+k] !== exp0[k]) begin errors++; $display("FAIL p3_row0_px%0d: got %b/%0d want 1/%0d", k, cap_ov[33+k], cap_od[33+k], exp0[k]); end
      checks++; if (cap_ov[53+k] !== 1'b1 || cap_od[53+k] !== exp1[k]) begin errors++; $display("FAIL p3_row1_px%0d: got %b/%0d want 1/%0d", k, cap_ov[53+k], cap_od[53+k], exp1[k]); end
    end
    checks++; if (cap_dn[92] !== 1'b1) begin errors++; $display("FAIL p3_done: got %b want 1", cap_dn[92]); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    iStart     = 1'b0;
    iPattern   = 2'd0;
    iValid     = 1'b0;
    iR         = 8'd0;
    iG         = 8'd0;
    iB         = 8'd0;
    iDrainDone = 1'b0;
    test_reset();
    test_pattern0();
    test_pattern2();
    test_stall();
    test_drain_late();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
